// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch_type bit positions, fetch FSM state encoding
// and the default reset PC.
package cpu_pkg;

    localparam int BT_PC4   = 0;
    localparam int BT_BTYPE = 1;
    localparam int BT_JAL   = 2;
    localparam int BT_JALR  = 3;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch FSM states, kept as plain constants so older tools can read them.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_REQ   = 2'd0;
    localparam fetch_state_t ST_WAIT  = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;
    localparam fetch_state_t ST_FAULT = 2'd3;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel plus the IF/ID hand-off channel.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );
endinterface

// File: rtl/next_pc_calc.sv
// Redirect decode: target adders, jalr > jal > btype priority and the
// misaligned-target flag. Purely combinational.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic        branch_valid,
    input  logic [3:0]  branch_type,
    input  logic [31:0] pc_ex,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic        redirect,
    output logic [31:0] target,
    output logic        misaligned
);
    logic [31:0] rel_target;
    logic [31:0] jalr_sum;
    logic        pc4_unused;

    assign rel_target = pc_ex + imm;
    assign jalr_sum   = rs1_data + imm;
    // pc_4 only ever means "no redirect", so its bit carries no information here.
    assign pc4_unused = branch_type[BT_PC4];

    assign redirect = branch_valid &
                      (branch_type[BT_JALR] | branch_type[BT_JAL] | branch_type[BT_BTYPE]);

    always_comb begin
        target = rel_target;
        if (branch_type[BT_JALR]) begin
            target = {jalr_sum[31:1], 1'b0};
        end
    end

    assign misaligned = target[1];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end owning the architectural PC. Optional feature
// macro FETCH_MISALIGN_TRAP_EN traps redirects to non-word-aligned targets.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         branch_valid,
    input  logic [3:0]   branch_type,
    input  logic [31:0]  pc_ex,
    input  logic [31:0]  imm,
    input  logic [31:0]  rs1_data,
    output logic         flush,
    output logic         fetch_fault,
    fetch_unit_if.master bus
);
    fetch_state_t state;
    logic [31:0]  pc;
    logic         stale;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_instr;

    logic         redirect;
    logic [31:0]  target;
    logic         misaligned;
    logic         trap;
    logic         handshake;
    logic [31:0]  pc_inc;

    next_pc_calc u_next_pc (
        .branch_valid (branch_valid),
        .branch_type  (branch_type),
        .pc_ex        (pc_ex),
        .imm          (imm),
        .rs1_data     (rs1_data),
        .redirect     (redirect),
        .target       (target),
        .misaligned   (misaligned)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap        = redirect & misaligned;
    assign fetch_fault = (state == ST_FAULT);
`else
    logic misalign_unused;
    assign misalign_unused = misaligned;
    assign trap            = 1'b0;
    assign fetch_fault     = 1'b0;
`endif

    assign flush     = redirect;
    assign handshake = bus.imem_req_valid & bus.imem_req_ready;
    assign pc_inc    = pc + 32'd4;

    assign bus.imem_req_valid = (state == ST_REQ);
    assign bus.imem_req_addr  = {pc[31:2], 2'b00};
    assign bus.if_valid       = (state == ST_HOLD);
    assign bus.if_pc          = buf_pc;
    assign bus.if_instr       = buf_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_REQ;
            pc        <= RESET_PC;
            stale     <= 1'b0;
            buf_pc    <= 32'h0;
            buf_instr <= 32'h0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (redirect) begin
                        pc <= target;
                        if (trap) begin
                            state <= ST_FAULT;
                        end else if (handshake) begin
                            // The accepted fetch is for the old path; drop its response.
                            state <= ST_WAIT;
                            stale <= 1'b1;
                        end
                    end else if (handshake) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect && trap) begin
                        pc    <= target;
                        stale <= 1'b0;
                        state <= ST_FAULT;
                    end else if (bus.imem_resp_valid) begin
                        if (!stale && !redirect) begin
                            buf_pc    <= pc;
                            buf_instr <= bus.imem_resp_data;
                            pc        <= pc_inc;
                            state     <= ST_HOLD;
                        end else begin
                            stale <= 1'b0;
                            state <= ST_REQ;
                            if (redirect) begin
                                pc <= target;
                            end
                        end
                    end else if (redirect) begin
                        pc    <= target;
                        stale <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= trap ? ST_FAULT : ST_REQ;
                    end else if (bus.if_ready) begin
                        state <= ST_REQ;
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that consumes the one-hot `branch_type` vector produced by branch resolution and owns the architectural PC. Issues at most one instruction-memory request at a time over a valid/ready channel. Buffers the returned instruction toward decode and squashes stale fetches when a redirect arrives. Sits between the EX-stage branch logic and the IF/ID boundary.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded by reset.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `branch_valid`  in  1  EX stage presents a resolved instruction this cycle.
- `branch_type`  in  4  one-hot {jalr, jal, btype_taken, pc_4}.
- `pc_ex`  in  32  PC of the resolving instruction.
- `imm`  in  32  sign-extended immediate of that instruction.
- `rs1_data`  in  32  rs1 operand (jalr base).
- `flush`  out  1  squash younger pipeline stages.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  word address, bits [1:0] forced 0.
- `imem_resp_valid`  in  1  instruction returned (one per accepted request, in order, no backpressure).
- `imem_resp_data`  in  32  instruction word.
- `if_valid`  out  1  buffered instruction available to decode.
- `if_ready`  in  1  decode accepts.
- `if_pc`  out  32  PC of buffered instruction.
- `if_instr`  out  32  buffered instruction.
- `fetch_fault`  out  1  misaligned target trapped (tied 0 when feature compiled out).

## Operation
- Redirect: `redirect = branch_valid & (branch_type[3] | branch_type[2] | branch_type[1])`. Priority is jalr > jal > btype; all-zero or pc_4 means no redirect.
- Target: btype/jal use `pc_ex + imm`; jalr uses `(rs1_data + imm) & ~1`. All sums are 32-bit modulo, with carry discarded.
- `flush = redirect`, combinational.
- Sequential PC increment is `pc + 4` modulo 2^32 (0xFFFF_FFFC wraps to 0).
- FSM states: REQ, WAIT, HOLD, FAULT. Reset puts the FSM in REQ, `pc = RESET_PC`, `stale = 0`.
- REQ: `imem_req_valid = 1`, `imem_req_addr = pc`.
  - On handshake, go to WAIT.
  - Redirect without handshake: `pc <= target`, stay in REQ.
  - Redirect with handshake: `pc <= target`, go to WAIT with `stale <= 1`.
- WAIT: no request.
  - Redirect: `pc <= target`, `stale <= 1`.
  - On `imem_resp_valid` with `stale` clear and no redirect this cycle: `if_pc <= pc`, `if_instr <= data`, `pc <= pc + 4`, go to HOLD.
  - On `imem_resp_valid` with `stale` set or redirect this cycle: discard the response, clear `stale`, go to REQ.
- HOLD: `if_valid = 1`.
  - `if_valid & if_ready` with no redirect: go to REQ.
  - Redirect: `pc <= target`, drop the buffer, go to REQ. `if_valid` is 0 next cycle, regardless of `if_ready`.
- Reset mid-operation: the FSM returns to REQ and the buffer is dropped. The instruction memory shares `rst` and discards any in-flight response.

## Timing
- Reset values: `imem_req_valid = 1`, `imem_req_addr = RESET_PC`, `if_valid = 0`, `if_pc = 0`, `if_instr = 0`, `fetch_fault = 0`, `flush = 0`.
- Redirect latency: redirect in cycle N puts the target on `imem_req_addr` in cycle N+1 at the earliest.
- Fetch latency: request accepted in cycle N, response in cycle M > N, `if_valid` high in cycle M+1.
- Steady-state throughput is one instruction per 3 cycles with single-cycle memory.
- A stale instruction never appears with `if_valid = 1`.
- Outputs other than `flush` are registered or FSM-decoded. There is no combinational path from `if_ready` to `imem_req_valid`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect whose target has bit 1 set goes to FAULT.
  - FAULT drives `fetch_fault = 1`, `imem_req_valid = 0`, `if_valid = 0`, and is left only by `rst`.
  - In FAULT, `pc` holds the faulting target.
  - A response still outstanding when FAULT is entered is discarded.
- Undefined: no check. `fetch_fault` is tied 0 and the target's low bits are masked on `imem_req_addr`.

## Structure
- Shared package `cpu_pkg`:
  - `branch_type` bit indices `BT_PC4 = 0`, `BT_BTYPE = 1`, `BT_JAL = 2`, `BT_JALR = 3`.
  - Fetch state enum.
  - Default reset-PC constant.
- One combinational sub-module, `next_pc_calc`: target adders, priority select and the misalignment flag.

## Test plan
- Reset, memory ready with 1-cycle response: first request address 0x0, then 0x4 and 0x8; `if_pc` sequence 0x0, 0x4, 0x8.
- jal redirect with `pc_ex = 0x100`, `imm = 0x40` during WAIT: `flush` high that cycle; the in-flight response is dropped; next request address 0x140; no `if_valid` for the old PC.
- jalr with `rs1_data = 0x2001`, `imm = 0x4`: target 0x2004; simultaneously asserting jal and btype bits still selects jalr.
- Redirect while in HOLD with `if_ready = 0`: `if_valid` falls next cycle; next request address is the target.
- Redirect in the same cycle as `imem_resp_valid`: the response is discarded; `if_valid` stays 0; the request goes to the target. With `pc = 0xFFFF_FFFC`, the next sequential request address is 0x0.
- With `FETCH_MISALIGN_TRAP_EN`, btype target 0x102: `fetch_fault` stays 1 and there are no further requests until `rst`. Without the macro, the request address is 0x100.
